// File: rtl/hazard_scoreboard_pkg.sv
// rtl/hazard_scoreboard_pkg.sv - shared types for the hazard scoreboard
package hazard_scoreboard_pkg;

  localparam int XLEN  = 64;
  localparam int REG_W = 5;

  typedef logic [REG_W-1:0] reg_idx_t;

  typedef enum logic [1:0] {
    K_ALU   = 2'd0,
    K_LOAD  = 2'd1,
    K_MULTI = 2'd2
  } wb_kind_t;

  typedef struct packed {
    logic            valid;
    reg_idx_t        dst;
    logic [XLEN-1:0] data;
  } fwd_data_t;

  typedef struct packed {
    logic     valid;
    reg_idx_t dst;
    wb_kind_t kind;
  } sb_slot_t;

  // A writer sitting in EX whose value cannot be forwarded this cycle.
  function automatic logic ex_result_pending(wb_kind_t kind, logic ex_busy);
    return (kind == K_LOAD) || ((kind == K_MULTI) && ex_busy);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - pipeline-side bundle of the hazard scoreboard
interface hazard_scoreboard_if #(
  parameter int CNT_W = 32
);
  import hazard_scoreboard_pkg::*;

  logic            id_valid;
  reg_idx_t        id_rs1;
  reg_idx_t        id_rs2;
  logic            id_wen;
  reg_idx_t        id_rd;
  wb_kind_t        id_kind;
  logic            flush;
  logic            ex_busy;
  logic [XLEN-1:0] ex_result;
  logic            mem_stall;
  logic [XLEN-1:0] mem_result;
  logic [XLEN-1:0] mem_rdata;
  fwd_data_t       ex_fwd;
  fwd_data_t       mem_fwd;
  logic            stall_id;
  logic            stall_ex;
  logic            stall_mem;
  logic            wb_wen;
  reg_idx_t        wb_dst;
  logic [XLEN-1:0] wb_data;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_wen, id_rd, id_kind, flush,
           ex_busy, ex_result, mem_stall, mem_result, mem_rdata,
    input  ex_fwd, mem_fwd, stall_id, stall_ex, stall_mem,
           wb_wen, wb_dst, wb_data, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_wen, id_rd, id_kind, flush,
           ex_busy, ex_result, mem_stall, mem_result, mem_rdata,
    output ex_fwd, mem_fwd, stall_id, stall_ex, stall_mem,
           wb_wen, wb_dst, wb_data, stall_cnt
  );

endinterface

// File: rtl/hazard_scoreboard_match.sv
// rtl/hazard_scoreboard_match.sv - RAW hazard compare of one source register
module hazard_match
  import hazard_scoreboard_pkg::*;
(
  input  logic     id_valid,
  input  reg_idx_t rs,
  input  sb_slot_t ex_slot,
  input  sb_slot_t mem_slot,
  input  logic     ex_busy,
  input  logic     mem_stall,
  output logic     hazard
);

  logic ex_hit;
  logic mem_hit;

  always_comb begin
    ex_hit  = ex_slot.valid && (ex_slot.dst == rs) &&
              ex_result_pending(ex_slot.kind, ex_busy);
    mem_hit = mem_slot.valid && (mem_slot.dst == rs) &&
              (mem_slot.kind == K_LOAD) && mem_stall;
    hazard  = id_valid && (rs != '0) && (ex_hit || mem_hit);
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - in-flight writer tracking, forwarding and stall generation
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NREG  = 32,
  parameter int CNT_W = 32
) (
  input logic               clk,
  input logic               reset,
  hazard_scoreboard_if.slave sb
);

  localparam int IDX_W = $clog2(NREG);
  localparam sb_slot_t BUBBLE = '{valid: 1'b0, dst: '0, kind: K_ALU};

  sb_slot_t         ex_q, ex_d;
  sb_slot_t         mem_q, mem_d;
  sb_slot_t         wb_q, wb_d;
  logic [XLEN-1:0]  wb_data_q, wb_data_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic            haz_rs1, haz_rs2;
  logic            stall_mem, stall_ex, stall_id;
  logic            id_alloc;
  logic [XLEN-1:0] mem_data;

  hazard_match u_match_rs1 (
    .id_valid (sb.id_valid),
    .rs       (sb.id_rs1),
    .ex_slot  (ex_q),
    .mem_slot (mem_q),
    .ex_busy  (sb.ex_busy),
    .mem_stall(sb.mem_stall),
    .hazard   (haz_rs1)
  );

  hazard_match u_match_rs2 (
    .id_valid (sb.id_valid),
    .rs       (sb.id_rs2),
    .ex_slot  (ex_q),
    .mem_slot (mem_q),
    .ex_busy  (sb.ex_busy),
    .mem_stall(sb.mem_stall),
    .hazard   (haz_rs2)
  );

  always_comb begin
    stall_mem = sb.mem_stall;
    stall_ex  = sb.mem_stall | sb.ex_busy;
    stall_id  = stall_ex | haz_rs1 | haz_rs2;
    id_alloc  = !stall_id && !sb.flush && sb.id_valid && sb.id_wen &&
                (sb.id_rd != IDX_W'(0));
    mem_data  = (mem_q.kind == K_LOAD) ? sb.mem_rdata : sb.mem_result;

    wb_d      = wb_q;
    wb_data_d = wb_data_q;
    if (!stall_mem) begin
      wb_d      = mem_q;
      wb_data_d = mem_data;
    end else begin
      wb_d.valid = 1'b0;
    end

    // EX held while MEM drains leaves a hole in MEM.
    if (!stall_ex)      mem_d = ex_q;
    else if (stall_mem) mem_d = mem_q;
    else                mem_d = BUBBLE;

    // A flush or RAW stall drops the ID instruction; a held EX keeps its entry.
    if (id_alloc)      ex_d = '{valid: 1'b1, dst: sb.id_rd, kind: sb.id_kind};
    else if (stall_ex) ex_d = ex_q;
    else               ex_d = BUBBLE;

    stall_cnt_d = stall_cnt_q + CNT_W'(stall_id);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q        <= BUBBLE;
      mem_q       <= BUBBLE;
      wb_q        <= BUBBLE;
      wb_data_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      wb_data_q   <= wb_data_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    sb.stall_mem     = stall_mem;
    sb.stall_ex      = stall_ex;
    sb.stall_id      = stall_id;
    sb.ex_fwd.valid  = ex_q.valid && !ex_result_pending(ex_q.kind, sb.ex_busy);
    sb.ex_fwd.dst    = ex_q.dst;
    sb.ex_fwd.data   = sb.ex_result;
    sb.mem_fwd.valid = mem_q.valid && !((mem_q.kind == K_LOAD) && sb.mem_stall);
    sb.mem_fwd.dst   = mem_q.dst;
    sb.mem_fwd.data  = mem_data;
    sb.wb_wen        = wb_q.valid;
    sb.wb_dst        = wb_q.dst;
    sb.wb_data       = wb_data_q;
    sb.stall_cnt     = stall_cnt_q;
  end

endmodule
